// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: Moore sequencer plus parallel-in/serial-out shifter.
// Loads a WIDTH-bit word, shifts it out MSB- or LSB-first with optional
// stalling, then pulses done for one cycle before returning to IDLE.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             msb_first,
  input  logic             hold,
  input  logic [WIDTH-1:0] data_in,
  output logic             load,
  output logic             shift,
  output logic             serial_out,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic             order;
  logic             shift_en;
  logic             last_bit;

  // A bit is consumed only in SHIFT when not stalled.
  assign shift_en = (state == SHIFT) && !hold;
  assign last_bit = (bit_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; any unexpected encoding falls back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   state_nxt = (shift_en && last_bit) ? DONE : SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output decode; shift additionally gates on hold.
  always_comb begin
    load       = 1'b0;
    shift      = 1'b0;
    serial_out = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      SHIFT: begin
        busy       = 1'b1;
        shift      = !hold;
        serial_out = order ? sreg[WIDTH-1] : sreg[0];
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  // Datapath: word capture, zero-fill shifting toward the output end, bit count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg    <= '0;
      order   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (state == LOAD) begin
        sreg    <= data_in;
        order   <= msb_first;
        bit_cnt <= '0;
      end else if (shift_en) begin
        sreg    <= order ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (state == DONE) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl at WIDTH = 8, 2 and 64.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        msb_first;
  logic        hold;
  logic [63:0] data;
  int          sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic       l8, s8, so8, b8, d8;
  logic [3:0] c8;
  logic       l2, s2, so2, b2, d2;
  logic [1:0] c2;
  logic       l64, s64, so64, b64, d64;
  logic [6:0] c64;

  shift_seq_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .start(start && (sel == 0)), .msb_first(msb_first),
    .hold(hold), .data_in(data[7:0]), .load(l8), .shift(s8), .serial_out(so8),
    .bit_cnt(c8), .busy(b8), .done(d8)
  );

  shift_seq_ctrl #(.WIDTH(2)) u_w2 (
    .clk(clk), .reset(reset), .start(start && (sel == 1)), .msb_first(msb_first),
    .hold(hold), .data_in(data[1:0]), .load(l2), .shift(s2), .serial_out(so2),
    .bit_cnt(c2), .busy(b2), .done(d2)
  );

  shift_seq_ctrl #(.WIDTH(64)) u_w64 (
    .clk(clk), .reset(reset), .start(start && (sel == 2)), .msb_first(msb_first),
    .hold(hold), .data_in(data), .load(l64), .shift(s64), .serial_out(so64),
    .bit_cnt(c64), .busy(b64), .done(d64)
  );

  logic       o_load, o_shift, o_ser, o_busy, o_done;
  logic [6:0] o_cnt;

  // View of the instance currently under test.
  always_comb begin
    o_load = l8; o_shift = s8; o_ser = so8; o_busy = b8; o_done = d8; o_cnt = 7'(c8);
    if (sel == 1) begin
      o_load = l2; o_shift = s2; o_ser = so2; o_busy = b2; o_done = d2; o_cnt = 7'(c2);
    end else if (sel == 2) begin
      o_load = l64; o_shift = s64; o_ser = so64; o_busy = b64; o_done = d64; o_cnt = c64;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete transfer; exp_stream holds the bits in transmission order, first bit at [w-1].
  task automatic run_word(input string tag, input int w, input logic [63:0] d, input logic m,
                          input logic [63:0] exp_stream, input int hold_at, input int hold_len,
                          input logic toggle);
    int bit_i = 0;
    int holds = 0;
    @(negedge clk);
    start = 1'b1; data = d; msb_first = m; hold = 1'b0;
    #1;
    check({tag, " idle_load"}, 64'(o_load), 64'd0);
    @(negedge clk);
    start = 1'b0; hold = 1'b1;
    #1;
    check({tag, " load"}, 64'(o_load), 64'd1);
    check({tag, " load_busy"}, 64'(o_busy), 64'd1);
    check({tag, " load_ser"}, 64'(o_ser), 64'd0);
    for (int c = 0; c < w + hold_len; c++) begin
      @(negedge clk);
      data = ~d; msb_first = ~m;
      start = toggle ? 1'(c & 1) : 1'b0;
      if (bit_i == hold_at && holds < hold_len) begin
        hold = 1'b1;
        holds++;
      end else begin
        hold = 1'b0;
      end
      #1;
      check({tag, " shift"}, 64'(o_shift), 64'(!hold));
      check({tag, " ser"}, 64'(o_ser), 64'(exp_stream[w-1-bit_i]));
      check({tag, " cnt"}, 64'(o_cnt), 64'(bit_i));
      check({tag, " busy"}, 64'(o_busy), 64'd1);
      check({tag, " no_load"}, 64'(o_load), 64'd0);
      if (!hold) bit_i++;
    end
    @(negedge clk);
    hold = 1'b0; start = toggle;
    #1;
    check({tag, " done"}, 64'(o_done), 64'd1);
    check({tag, " done_cnt"}, 64'(o_cnt), 64'(w));
    check({tag, " done_busy"}, 64'(o_busy), 64'd0);
    check({tag, " done_ser"}, 64'(o_ser), 64'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, " idle_done"}, 64'(o_done), 64'd0);
    check({tag, " idle_load2"}, 64'(o_load), 64'd0);
    @(negedge clk);
    #1;
    check({tag, " no_restart"}, 64'(o_load), 64'd0);
  endtask

  initial begin
    int n_loads;
    int load_at [3];
    int n_done;

    reset = 1'b0; start = 1'b0; msb_first = 1'b0; hold = 1'b0; data = '0; sel = 0;
    #2;
    check("rst_load", 64'(l8), 64'd0);
    check("rst_shift", 64'(s8), 64'd0);
    check("rst_ser", 64'(so8), 64'd0);
    check("rst_busy", 64'(b8), 64'd0);
    check("rst_done", 64'(d8), 64'd0);
    check("rst_cnt", 64'(c8), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_word("a5_msb", 8, 64'hA5, 1'b1, 64'hA5, -1, 0, 1'b0);
    run_word("a5_lsb", 8, 64'hA5, 1'b0, 64'hA5, -1, 0, 1'b0);
    run_word("01_lsb", 8, 64'h01, 1'b0, 64'h80, -1, 0, 1'b0);
    run_word("01_msb", 8, 64'h01, 1'b1, 64'h01, -1, 0, 1'b0);
    run_word("c3_hold", 8, 64'hC3, 1'b1, 64'hC3, 2, 3, 1'b0);
    run_word("96_tog", 8, 64'h96, 1'b0, 64'h69, 5, 1, 1'b1);

    // start held high: loads every WIDTH+3 cycles
    n_loads = 0;
    load_at = '{-1, -1, -1};
    for (int c = 0; c <= 32; c++) begin
      @(negedge clk);
      start = 1'b1; data = 64'h5A; msb_first = 1'b1;
      #1;
      if (o_load) begin
        if (n_loads < 3) load_at[n_loads] = c;
        n_loads++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("b2b_count", 64'(n_loads), 64'd3);
    check("b2b_first", 64'(load_at[0]), 64'd1);
    check("b2b_second", 64'(load_at[1]), 64'd12);
    check("b2b_third", 64'(load_at[2]), 64'd23);

    // reset asserted mid-word at bit_cnt = 4
    @(negedge clk);
    start = 1'b1; data = 64'hFF; msb_first = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("mid_cnt4", 64'(o_cnt), 64'd4);
    reset = 1'b0;
    #1;
    check("mid_rst_shift", 64'(o_shift), 64'd0);
    check("mid_rst_ser", 64'(o_ser), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_cnt", 64'(o_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (o_done || o_busy) n_done++;
    end
    check("mid_no_done", 64'(n_done), 64'd0);
    run_word("post_rst", 8, 64'h3C, 1'b1, 64'h3C, -1, 0, 1'b0);

    sel = 1;
    run_word("w2_msb", 2, 64'h3, 1'b1, 64'h3, -1, 0, 1'b0);
    run_word("w2_lsb", 2, 64'h2, 1'b0, 64'h1, -1, 0, 1'b0);
    run_word("w2_hold", 2, 64'h2, 1'b1, 64'h2, 1, 2, 1'b0);

    sel = 2;
    run_word("w64_ones", 64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 1'b0);
    run_word("w64_alt", 64, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'h5555_5555_5555_5555, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
